// File: rtl/fancy_timer_pkg.sv
// Shared types and helpers for the serial-command timer.
// States are one-hot; bit indices name each state.
package fancy_timer_pkg;

   localparam int SEARCH = 0;
   localparam int SHIFT  = 1;
   localparam int COUNT  = 2;
   localparam int WAIT   = 3;

   typedef enum logic [3:0] {
      S_SEARCH = 4'b0001,
      S_SHIFT  = 4'b0010,
      S_COUNT  = 4'b0100,
      S_WAIT   = 4'b1000
   } state_t;

   function automatic int unit_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fancy_timer_if.sv
// Serial command and status bundle of the timer.
// The master drives d/ack; the slave reports status.
interface fancy_timer_if #(
   parameter int DELAY_W = 4
);
   logic               d;
   logic               ack;
   logic               shift_ena;
   logic               counting;
   logic               done;
   logic [DELAY_W-1:0] count;
   logic [3:0]         state_onehot;

   modport master (
      output d, ack,
      input  shift_ena, counting, done, count, state_onehot
   );

   modport slave (
      input  d, ack,
      output shift_ena, counting, done, count, state_onehot
   );
endinterface

// File: rtl/fancy_timer_pattern_match.sv
// Overlap-aware start-pattern detector on the serial input.
// Fill tracks how many valid history bits have been seen.
module fancy_timer_pattern_match
   import fancy_timer_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   input  logic enable,
   input  logic clear,
   output logic match
);
   localparam int HW = PAT_W - 1;
   localparam int FW = unit_w(PAT_W);
   localparam logic [FW-1:0] FILL_MAX = FW'(HW);

   logic [HW-1:0]    hist;
   logic [FW-1:0]    fill;
   logic [PAT_W-1:0] win;

   assign win   = {hist, d};
   assign match = enable && (fill == FILL_MAX) && (win == PATTERN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '0;
         fill <= '0;
      end else if (clear) begin
         hist <= '0;
         fill <= '0;
      end else if (enable) begin
         hist <= win[HW-1:0];
         if (fill != FILL_MAX)
            fill <= fill + FW'(1);
      end
   end
endmodule

// File: rtl/fancy_timer_fsm.sv
// Serial-command timer: find pattern, shift delay, count, wait ack.
// Counting lasts (delay+1)*UNIT_CYCLES cycles.
module fancy_timer_fsm
   import fancy_timer_pkg::*;
#(
   parameter int               PAT_W       = 4,
   parameter logic [PAT_W-1:0] PATTERN     = 4'b1101,
   parameter int               DELAY_W     = 4,
   parameter int               UNIT_CYCLES = 1000
) (
   input logic          clk,
   input logic          rst_n,
   fancy_timer_if.slave bus
);
   localparam int UW = unit_w(UNIT_CYCLES);
   localparam int BW = unit_w(DELAY_W);
   localparam logic [UW-1:0] RELOAD   = UW'(UNIT_CYCLES - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DELAY_W - 1);

   state_t             state;
   state_t             next;
   logic [DELAY_W-1:0] count;
   logic [BW-1:0]      bit_cnt;
   logic [UW-1:0]      unit_cnt;
   logic [DELAY_W:0]   shifted;
   logic               match;
   logic               clear;
   logic               unit_end;
   logic               bits_end;
   logic               searching;

   assign searching = (state == S_SEARCH);
   assign clear     = (state == S_WAIT) && bus.ack;
   assign unit_end  = (unit_cnt == '0);
   assign bits_end  = (bit_cnt == LAST_BIT);
   assign shifted   = {count, bus.d};
   assign bus.count = count;

   fancy_timer_pattern_match #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_match (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (bus.d),
      .enable (searching),
      .clear  (clear),
      .match  (match)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_SEARCH;
      else
         state <= next;
   end

   // Unknown (non-one-hot) encodings fall to the default and recover.
   always_comb begin
      next               = S_SEARCH;
      bus.shift_ena      = 1'b0;
      bus.counting       = 1'b0;
      bus.done           = 1'b0;
      bus.state_onehot   = state;
      case (state)
         S_SEARCH: next = match ? S_SHIFT : S_SEARCH;
         S_SHIFT: begin
            bus.shift_ena = 1'b1;
            next = bits_end ? S_COUNT : S_SHIFT;
         end
         S_COUNT: begin
            bus.counting = 1'b1;
            next = (unit_end && count == '0) ? S_WAIT : S_COUNT;
         end
         S_WAIT: begin
            bus.done = 1'b1;
            next = bus.ack ? S_SEARCH : S_WAIT;
         end
         default: next = S_SEARCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         bit_cnt  <= '0;
         unit_cnt <= '0;
      end else begin
         case (state)
            S_SEARCH: begin
               if (match)
                  bit_cnt <= '0;
            end
            S_SHIFT: begin
               count <= shifted[DELAY_W-1:0];
               if (bits_end)
                  unit_cnt <= RELOAD;
               else
                  bit_cnt <= bit_cnt + BW'(1);
            end
            S_COUNT: begin
               if (!unit_end) begin
                  unit_cnt <= unit_cnt - UW'(1);
               end else if (count != '0) begin
                  count    <= count - DELAY_W'(1);
                  unit_cnt <= RELOAD;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/fancy_timer_fsm.md
Name: fancy_timer_fsm

Overview:
Complete sequential serial-command timer. It searches a serial bit stream `d` for a start pattern, then shifts in a DELAY_W-bit delay value MSB-first. It then counts (delay+1)*UNIT_CYCLES cycles, raises `done`, and waits for `ack` before searching again. It replaces the hand-coded fixed 1101 / 4-bit one-hot next-state logic with a registered, parametrised FSM that owns its own state, counters and remaining-time output.

Parameters:
PAT_W, 4, start-pattern length in bits (>=2).
PATTERN, 4'b1101, start pattern; MSB is received first.
DELAY_W, 4, delay field width in bits, shifted MSB-first (>=1).
UNIT_CYCLES, 1000, clock cycles per delay unit (>=1); internal counter width is $clog2(UNIT_CYCLES) (min 1).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
d  in  1  serial data input.
ack  in  1  user acknowledge; only sampled in WAIT.
shift_ena  out  1  high while delay bits are being captured.
counting  out  1  high while timing.
done  out  1  high while waiting for ack.
count  out  DELAY_W  delay register: remaining delay units while counting.
state_onehot  out  4  current state, one-hot {WAIT,COUNT,SHIFT,SEARCH}.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=SEARCH, state_onehot=4'b0001, shift_ena=counting=done=0, count=0, pattern history=0, fill=0, bit counter=0, unit counter=0.
- Reset asserted in any state (including mid-SHIFT or mid-COUNT) returns to these values immediately. The block restarts in SEARCH on the first edge after release.
- Output timing: shift_ena, counting and done are Moore outputs, decoded only from the state register: SHIFT, COUNT and WAIT respectively.
- SEARCH:
  - Each cycle, d is shifted into a (PAT_W-1)-bit history. A fill counter saturates at PAT_W-1.
  - Match condition: {history, d} == PATTERN and fill == PAT_W-1. This is overlap-aware; e.g. 1,1,1,0,1 matches on the 5th bit.
  - On a match the next state is SHIFT, and the bit counter is cleared.
- SHIFT:
  - Lasts exactly DELAY_W cycles. Each cycle, count <= {count[DELAY_W-2:0], d} (for DELAY_W=1, count <= d).
  - The cycle that captures the DELAY_W-th bit moves to COUNT and loads unit counter = UNIT_CYCLES-1.
- COUNT:
  - Each cycle, the unit counter decrements.
  - When unit counter == 0: if count == 0, go to WAIT; else count <= count-1 and reload the unit counter to UNIT_CYCLES-1.
  - Total cycles with counting=1 is exactly (D+1)*UNIT_CYCLES, where D is the captured delay. `count` shows D for the first UNIT_CYCLES cycles, D-1 for the next block, and so on down to 0.
- WAIT:
  - done=1 and count=0. d is ignored.
  - ack=1 moves to SEARCH next edge and clears history and fill, so a new pattern needs PAT_W fresh bits. ack=0 stays in WAIT.
- General rules:
  - ack is ignored in SEARCH, SHIFT and COUNT.
  - d is ignored in COUNT and WAIT.
  - No illegal states are reachable. Any non-one-hot state register value recovers to SEARCH next edge.

Decomposition:
- Shared package fancy_timer_pkg:
  - State index constants SEARCH=0, SHIFT=1, COUNT=2, WAIT=3.
  - typedef state_t as a 4-bit one-hot vector.
  - A function to compute the unit counter width.
- One sub-module, fancy_timer_pattern_match:
  - Contains the history shift register and fill counter.
  - Inputs: clk, rst_n, d, enable, clear. Output: match.
  - Parameters: PAT_W, PATTERN.

Test Plan:
1. Reset: hold rst_n=0, toggle d and ack → state_onehot=4'b0001, all outputs 0, count=0. Asserting rst_n low between edges clears outputs without a clock edge.
2. Nominal run (UNIT_CYCLES=4): d=1,1,0,1 then 0,0,1,0 → shift_ena high exactly 4 cycles; counting high exactly 12 cycles with count=2,1,0 for 4 cycles each; done high until ack=1, then SEARCH next edge.
3. Overlap and false starts: d=1,1,1,0,1 → SHIFT entered after the 5th bit. d=1,1,0,0,1,1,0,1 → match only on the 8th bit.
4. Delay extremes (UNIT_CYCLES=4): delay=0 → counting exactly 4 cycles. Delay=4'hF → counting exactly 64 cycles, count steps from 15 down to 0.
5. Mid-operation reset: assert rst_n=0 in COUNT with count=1 → immediate return to SEARCH, outputs 0. A fresh pattern is required afterwards.
6. ack handling: ack=1 held through SEARCH, SHIFT and COUNT → no effect; done still asserts. After ack in WAIT, the stale history 1,1,0 plus d=1 does not match; a full new 1,1,0,1 is required.
